packet_rx_buffer: RTL and testbench
===================================

Name: packet_rx_buffer

Overview:
- Store-and-forward receiver sitting at the tx end of a stream-processing element.
- Accepts first/last-framed 32-bit word packets on its rx interface and buffers them.
- Re-emits only complete, well-formed packets on its tx interface. Malformed or oversize packets are discarded whole, so downstream never sees a partial packet.

Parameters:
- DEPTH, 64, buffer entries (words); power of two, at least 4.
- WIDTH, 32, payload width in bits.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- valid_rx  in  1  upstream word valid.
- ready_rx  out  1  buffer can accept the word.
- first_rx  in  1  word is first of packet.
- last_rx  in  1  word is last of packet.
- payload_rx  in  WIDTH  word data.
- valid_tx  out  1  committed word available.
- ready_tx  in  1  downstream accepts word.
- first_tx  out  1  stored first flag of head word.
- last_tx  out  1  stored last flag of head word.
- payload_tx  out  WIDTH  head word data.
- drop_pulse  out  1  one-cycle pulse per discarded packet or stray word.

Behaviour:
- Reset (async assert): pointers and counters cleared, state IDLE. Outputs: ready_rx=1, valid_tx=0, first_tx=0, last_tx=0, payload_tx=0, drop_pulse=0.
- Storage: memory of DEPTH entries, each WIDTH+2 bits (payload, first, last).
- Pointers: rd_ptr, commit_ptr, wr_ptr, each log2(DEPTH)+1 bits so wrap-around is distinguishable.
- Full condition: wr_ptr − rd_ptr == DEPTH.
- Handshakes:
  - A word transfers on an edge where valid and ready are both high.
  - valid_tx/payload_tx/first_tx/last_tx hold stable while valid_tx=1 and ready_tx=0.
  - ready_tx is never required for valid_tx to assert.
- State IDLE (no packet open):
  - rx word with first=1, last=0: write it, wr_ptr++, go to RECV.
  - rx word with first=1, last=1: write it, wr_ptr++, commit_ptr = new wr_ptr, stay IDLE.
  - rx word with first=0: accept (ready_rx=1) but do not write; drop_pulse=1 next cycle.
- State RECV (packet open):
  - rx word with first=0: write it, wr_ptr++.
  - If last=1 on that word: commit_ptr = new wr_ptr, go to IDLE.
  - rx word with first=1 (restart): wr_ptr rewinds to commit_ptr, drop_pulse=1; then handle the word as in IDLE, in the same cycle.
  - Full, and rd_ptr == commit_ptr (open packet fills the whole buffer): wr_ptr rewinds to commit_ptr, drop_pulse=1, go to DROP.
  - Full otherwise: ready_rx=0 (backpressure) until space frees.
- State DROP:
  - ready_rx=1; accept and discard words.
  - Word with last=1: go to IDLE.
  - Word with first=1: handle as in IDLE.
- ready_rx: 0 only in the RECV/IDLE full case; always 1 in DROP.
- Read side:
  - Registered output stage.
  - Committed words (rd_ptr < commit_ptr) are prefetched into it.
  - Latency: last word accepted at edge k gives the packet's first word valid_tx=1 after edge k+1 at earliest, when the buffer was previously empty.
  - Sustained throughput is 1 word/cycle on both sides.
- Simultaneous read and write in one cycle: both occur; the full test uses the pre-edge rd_ptr, so no bypass is required.
- Reset mid-packet: all buffered data is lost and no drop_pulse is emitted.

Optional Feature:
- Macro: PACKET_RX_BUFFER_STATS_EN.
- Defined: adds outputs drop_count (16 bits) and pkt_count (16 bits).
  - drop_count increments with each drop_pulse; pkt_count increments at each commit.
  - Both saturate at 0xFFFF and clear on rst.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Packet of 3 words (0xA0, 0xA1, 0xA2; first on word 0, last on word 2), ready_tx=1 -> tx emits A0/A1/A2 in order with first only on A0 and last only on A2. A0 is valid after edge k+1, where k is the edge accepting A2. drop_pulse stays 0.
- Single-word packet 0x55 (first=last=1), then stray word 0x66 (first=0) while IDLE -> tx emits 0x55 with first=last=1. One drop_pulse; 0x66 never appears.
- Words 0x10, 0x11 (first on 0x10), then 0x20 with first=1, then 0x21 with last=1 -> one drop_pulse; tx emits only 0x20, 0x21.
- DEPTH=4, ready_tx=0, 5-word packet -> after 4 writes, ready_rx stays 1. Enters DROP, drop_pulse once, remaining word discarded. valid_tx never asserts; a following 2-word packet is delivered intact.
- DEPTH=4, one committed 3-word packet held (ready_tx=0), new packet starts -> ready_rx=0 after 1 word. Raising ready_tx drains the old packet first, then the new packet is accepted and delivered. Pointers wrap correctly.
- Assert rst mid-RECV with 2 words buffered -> outputs immediately go to reset values; the next packet is delivered normally.

Source files
------------

// File: rtl/packet_rx_buffer.sv
// packet_rx_buffer: store-and-forward packet buffer that forwards only complete, well-formed packets.
// Define PACKET_RX_BUFFER_STATS_EN to add saturating drop_count/pkt_count outputs.
module packet_rx_buffer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_rx,
  output logic             ready_rx,
  input  logic             first_rx,
  input  logic             last_rx,
  input  logic [WIDTH-1:0] payload_rx,
  output logic             valid_tx,
  input  logic             ready_tx,
  output logic             first_tx,
  output logic             last_tx,
  output logic [WIDTH-1:0] payload_tx,
  output logic             drop_pulse
`ifdef PACKET_RX_BUFFER_STATS_EN
  ,
  output logic [15:0]      drop_count,
  output logic [15:0]      pkt_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;
  state_t state, state_nx;
  logic [WIDTH+1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, commit_ptr, rd_ptr, fe_ptr, base, wr_nx, commit_nx;
  logic full, ovf, acc, rewind, we, drop_evt, load, pop;
  // rd_ptr advances only when downstream takes the word, so the output register never frees a slot early
  always_comb begin
    full = (wr_ptr - rd_ptr) == FULL_LVL;
    ovf = state == RECV && full && rd_ptr == commit_ptr;
    ready_rx = ovf || state == DROP || !full;
    acc = valid_rx && ready_rx;
    rewind = ovf || (acc && first_rx && state == RECV);
    we = acc && (first_rx || (state == RECV && !ovf));
    base = rewind ? commit_ptr : wr_ptr;
    wr_nx = we ? base + ONE : base;
    commit_nx = (we && last_rx) ? wr_nx : commit_ptr;
    drop_evt = rewind || (acc && !first_rx && state == IDLE);
    state_nx = we ? (last_rx ? IDLE : RECV) :
               ovf ? ((acc && last_rx) ? IDLE : DROP) :
               (state == DROP && acc && last_rx) ? IDLE : state;
    pop = valid_tx && ready_tx;
    load = (!valid_tx || ready_tx) && fe_ptr != commit_ptr;
  end
  always_ff @(posedge clk) begin
    if (we) mem[base[AW-1:0]] <= {first_rx, last_rx, payload_rx};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      commit_ptr <= '0;
      rd_ptr <= '0;
      fe_ptr <= '0;
      drop_pulse <= 1'b0;
      valid_tx <= 1'b0;
      first_tx <= 1'b0;
      last_tx <= 1'b0;
      payload_tx <= '0;
    end else begin
      state <= state_nx;
      wr_ptr <= wr_nx;
      commit_ptr <= commit_nx;
      drop_pulse <= drop_evt;
      if (pop) rd_ptr <= rd_ptr + ONE;
      if (load) begin
        {first_tx, last_tx, payload_tx} <= mem[fe_ptr[AW-1:0]];
        fe_ptr <= fe_ptr + ONE;
      end
      valid_tx <= load || (valid_tx && !ready_tx);
    end
  end
`ifdef PACKET_RX_BUFFER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
      pkt_count <= '0;
    end else begin
      if (drop_evt && !(&drop_count)) drop_count <= drop_count + 16'd1;
      if (we && last_rx && !(&pkt_count)) pkt_count <= pkt_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_packet_rx_buffer.sv
// tb_packet_rx_buffer: directed and random checks of packet_rx_buffer against a queue-level packet model.
module tb_packet_rx_buffer;
  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  logic clk = 0, rst = 0;
  logic valid_rx = 0, first_rx = 0, last_rx = 0, ready_tx = 0;
  logic [WIDTH-1:0] payload_rx = '0;
  logic ready_rx, valid_tx, first_tx, last_tx, drop_pulse;
  logic [WIDTH-1:0] payload_tx;
`ifdef PACKET_RX_BUFFER_STATS_EN
  logic [15:0] drop_count, pkt_count;
`endif
  packet_rx_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .valid_rx(valid_rx), .ready_rx(ready_rx), .first_rx(first_rx), .last_rx(last_rx),
    .payload_rx(payload_rx),
    .valid_tx(valid_tx), .ready_tx(ready_tx), .first_tx(first_tx), .last_tx(last_tx),
    .payload_tx(payload_tx), .drop_pulse(drop_pulse)
`ifdef PACKET_RX_BUFFER_STATS_EN
    , .drop_count(drop_count), .pkt_count(pkt_count)
`endif
  );
  always #5 clk = ~clk;
  // model: committed-but-unconsumed words, words of the open packet, and receive mode (0 idle, 1 open, 2 dropping)
  logic [WIDTH+1:0] cq[$], op[$];
  int st = 0;
  int vec = 0, bad = 0, dps = 0;
  bit exp_drop = 0, vt_seen = 0, mon_en = 0;
  bit m_full, m_ovf, m_er;
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      vec++;
      if (drop_pulse !== exp_drop) begin
        bad++;
        $display("FAIL drop_pulse: got %b expected %b at %0t", drop_pulse, exp_drop, $time);
      end
      if (drop_pulse) dps++;
      m_full = (cq.size() + op.size()) == DEPTH;
      m_ovf = st == 1 && m_full && cq.size() == 0;
      m_er = m_ovf || st == 2 || !m_full;
      vec++;
      if (ready_rx !== m_er) begin
        bad++;
        $display("FAIL ready_rx: got %b expected %b at %0t", ready_rx, m_er, $time);
      end
      if (valid_tx) begin
        vt_seen = 1;
        vec++;
        if (cq.size() == 0) begin
          bad++;
          $display("FAIL tx_word: got %h expected no valid word at %0t", {first_tx, last_tx, payload_tx}, $time);
        end else begin
          if ({first_tx, last_tx, payload_tx} !== cq[0]) begin
            bad++;
            $display("FAIL tx_word: got %h expected %h at %0t", {first_tx, last_tx, payload_tx}, cq[0], $time);
          end
          if (ready_tx) void'(cq.pop_front());
        end
      end
      exp_drop = 0;
      if (m_ovf) begin
        exp_drop = 1;
        op.delete();
        st = 2;
      end
      if (valid_rx && m_er) begin
        if (first_rx) begin
          if (st == 1) exp_drop = 1;
          op.delete();
          op.push_back({first_rx, last_rx, payload_rx});
          st = 1;
        end else if (st == 0) exp_drop = 1;
        else if (st == 1) op.push_back({first_rx, last_rx, payload_rx});
        if (last_rx && st == 1) begin
          foreach (op[i]) cq.push_back(op[i]);
          op.delete();
        end
        if (last_rx) st = 0;
      end
    end
  end

  task automatic send(input bit f, input bit l, input logic [WIDTH-1:0] d);
    bit ok = 0;
    valid_rx = 1; first_rx = f; last_rx = l; payload_rx = d;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = ready_rx;
      @(posedge clk);
      #1;
    end
    valid_rx = 0;
    vec++;
    if (!ok) begin
      bad++;
      $display("FAIL send_timeout: word %h not accepted within 100 cycles", d);
    end
  endtask

  task automatic drain(input string tag);
    valid_rx = 0;
    ready_tx = 1;
    for (int i = 0; i < 60 && (cq.size() > 0 || valid_tx); i++) begin
      @(posedge clk);
      #1;
    end
    vec++;
    if (cq.size() > 0 || valid_tx) begin
      bad++;
      $display("FAIL %s_drain: %0d words still pending, expected 0", tag, cq.size());
    end
  endtask

  task automatic test_reset;
    #1 rst = 1;
    #1;
    vec += 6;
    if (ready_rx !== 1'b1) begin bad++; $display("FAIL reset_ready_rx: got %b expected 1", ready_rx); end
    if (valid_tx !== 1'b0) begin bad++; $display("FAIL reset_valid_tx: got %b expected 0", valid_tx); end
    if (first_tx !== 1'b0) begin bad++; $display("FAIL reset_first_tx: got %b expected 0", first_tx); end
    if (last_tx !== 1'b0) begin bad++; $display("FAIL reset_last_tx: got %b expected 0", last_tx); end
    if (payload_tx !== '0) begin bad++; $display("FAIL reset_payload_tx: got %h expected 0", payload_tx); end
    if (drop_pulse !== 1'b0) begin bad++; $display("FAIL reset_drop_pulse: got %b expected 0", drop_pulse); end
    @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_basic;
    int d0 = dps;
    ready_tx = 1;
    send(1, 0, 32'hA0);
    send(0, 0, 32'hA1);
    send(0, 1, 32'hA2);
    vec++;
    if (valid_tx !== 1'b0) begin bad++; $display("FAIL latency_early: valid_tx got %b expected 0", valid_tx); end
    @(posedge clk);
    #1;
    vec++;
    if ({valid_tx, first_tx, last_tx, payload_tx} !== {3'b110, 32'hA0}) begin
      bad++;
      $display("FAIL latency_first: got v%b f%b l%b %h expected v1 f1 l0 a0", valid_tx, first_tx, last_tx, payload_tx);
    end
    drain("basic");
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if (dps - d0 != 0) begin bad++; $display("FAIL basic_drops: got %0d expected 0", dps - d0); end
  endtask

  task automatic test_single_stray;
    int d0 = dps;
    send(1, 1, 32'h55);
    send(0, 0, 32'h66);
    drain("stray");
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if (dps - d0 != 1) begin bad++; $display("FAIL stray_drops: got %0d expected 1", dps - d0); end
  endtask

  task automatic test_restart;
    int d0 = dps;
    send(1, 0, 32'h10);
    send(0, 0, 32'h11);
    send(1, 0, 32'h20);
    send(0, 1, 32'h21);
    drain("restart");
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if (dps - d0 != 1) begin bad++; $display("FAIL restart_drops: got %0d expected 1", dps - d0); end
  endtask

  task automatic test_overflow;
    int d0 = dps;
    time t0;
    ready_tx = 0;
    vt_seen = 0;
    t0 = $time;
    send(1, 0, 32'h30);
    send(0, 0, 32'h31);
    send(0, 0, 32'h32);
    send(0, 0, 32'h33);
    send(0, 1, 32'h34);
    vec++;
    if ($time - t0 != 50) begin bad++; $display("FAIL overflow_stall: 5 words took %0t expected 50", $time - t0); end
    repeat (3) @(posedge clk);
    #1;
    vec += 2;
    if (vt_seen) begin bad++; $display("FAIL overflow_valid_tx: got 1 expected 0"); end
    if (dps - d0 != 1) begin bad++; $display("FAIL overflow_drops: got %0d expected 1", dps - d0); end
    ready_tx = 1;
    send(1, 0, 32'h40);
    send(0, 1, 32'h41);
    drain("overflow");
  endtask

  task automatic test_backpressure;
    ready_tx = 0;
    send(1, 0, 32'h50);
    send(0, 0, 32'h51);
    send(0, 1, 32'h52);
    repeat (2) @(posedge clk);
    #1;
    send(1, 0, 32'h60);
    valid_rx = 1; first_rx = 0; last_rx = 0; payload_rx = 32'h61;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec += 2;
      if (ready_rx !== 1'b0) begin bad++; $display("FAIL bp_ready_rx: got %b expected 0", ready_rx); end
      if ({valid_tx, payload_tx} !== {1'b1, 32'h50}) begin
        bad++;
        $display("FAIL bp_hold: got v%b %h expected v1 50", valid_tx, payload_tx);
      end
    end
    @(posedge clk);
    #1 ready_tx = 1;
    send(0, 0, 32'h61);
    send(0, 1, 32'h62);
    drain("backpressure");
  endtask

  task automatic test_reset_mid;
    int d0;
    ready_tx = 0;
    send(1, 1, 32'h70);
    send(1, 0, 32'h71);
    send(0, 0, 32'h72);
    vec++;
    if (valid_tx !== 1'b1) begin bad++; $display("FAIL rstmid_setup: valid_tx got %b expected 1", valid_tx); end
    #2 rst = 1;
    #1;
    vec += 4;
    if (valid_tx !== 1'b0) begin bad++; $display("FAIL rstmid_valid_tx: got %b expected 0", valid_tx); end
    if ({first_tx, last_tx, payload_tx} !== '0) begin bad++; $display("FAIL rstmid_tx_word: got %h expected 0", {first_tx, last_tx, payload_tx}); end
    if (ready_rx !== 1'b1) begin bad++; $display("FAIL rstmid_ready_rx: got %b expected 1", ready_rx); end
    if (drop_pulse !== 1'b0) begin bad++; $display("FAIL rstmid_drop: got %b expected 0", drop_pulse); end
`ifdef PACKET_RX_BUFFER_STATS_EN
    vec++;
    if ({drop_count, pkt_count} !== '0) begin bad++; $display("FAIL rstmid_stats: got %h expected 0", {drop_count, pkt_count}); end
`endif
    cq.delete(); op.delete(); st = 0; exp_drop = 0;
    @(posedge clk);
    #2 rst = 0;
    d0 = dps;
    ready_tx = 1;
    send(1, 0, 32'h80);
    send(0, 1, 32'h81);
    drain("rstmid");
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if (dps - d0 != 0) begin bad++; $display("FAIL rstmid_drops: got %0d expected 0", dps - d0); end
  endtask

  task automatic test_random;
    bit a, in_pkt = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      a = valid_rx && ready_rx;
      @(posedge clk);
      #1;
      ready_tx = ($urandom % 4) != 0;
      if (!valid_rx || a) begin
        valid_rx = ($urandom % 5) != 0;
        first_rx = in_pkt ? ($urandom % 10 == 0) : ($urandom % 8 != 0);
        last_rx = $urandom % 4 == 0;
        payload_rx = $urandom;
        if (valid_rx) in_pkt = (first_rx || in_pkt) && !last_rx;
      end
    end
    drain("random");
  endtask

  initial begin
    test_reset;
    mon_en = 1;
    test_basic;
    test_single_stray;
    test_restart;
    test_overflow;
    test_backpressure;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
